// File: rtl/crc_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// crc_serial_tx_pkg
//   Shared definitions for the serial CRC framer and its companion receiver /
//   checker: FSM state encoding, default frame geometry, default generator
//   polynomial and seed, and a helper that sizes the bit counter.
// ---------------------------------------------------------------------------
package crc_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_e;

    localparam int         DEF_DATA_W   = 7;
    localparam int         DEF_CRC_W    = 3;
    // x^3 + x + 1 with the implicit x^3 term dropped
    localparam logic [2:0] DEF_POLY     = 3'b011;
    localparam logic [2:0] DEF_CRC_INIT = 3'b000;

    // Counter must hold DATA_W-1 and CRC_W-1; never narrower than one bit.
    function automatic int cnt_width(input int data_w, input int crc_w);
        int m;
        m = (data_w > crc_w) ? data_w : crc_w;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/crc_serial_tx_lfsr_step.sv
// ---------------------------------------------------------------------------
// crc_serial_tx_lfsr_step
//   Combinational single-bit CRC LFSR update (Galois form). Shared between
//   the serial transmitter and a serial receiver.
//   Ports:
//     crc_i  [CRC_W-1:0]  current LFSR contents
//     bit_i               next message bit, MSB first
//     crc_o  [CRC_W-1:0]  LFSR contents after absorbing bit_i
//   CRC_W must be at least 2.
// ---------------------------------------------------------------------------
module crc_serial_tx_lfsr_step #(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = 3'b011
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic fb;

    // Feedback is the bit leaving the top of the register XOR the new input;
    // it decides whether the polynomial is subtracted this step.
    assign fb    = crc_i[CRC_W-1] ^ bit_i;
    assign crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_tx.sv
// ---------------------------------------------------------------------------
// crc_serial_tx
//   Serial CRC framer. Takes a parallel word over valid/ready, then shifts
//   out DATA_W payload bits MSB first followed by CRC_W CRC bits MSB first,
//   honouring downstream backpressure. The CRC is the remainder of
//   data * x^CRC_W modulo the generator, so an unmodified frame gives a zero
//   syndrome at the checker.
//   Ports:
//     clk, rst_n             clock (rising edge), async active-low reset
//     data_in/valid/ready    upstream word handshake (ready only in IDLE)
//     tx_bit/valid/ready     downstream serial bit handshake
//     tx_sof / tx_eof        first payload bit / last CRC bit markers
//     crc_out                CRC of last completed frame, held
//     frame_done             one-cycle pulse after the last CRC bit transfers
// ---------------------------------------------------------------------------
module crc_serial_tx
    import crc_serial_tx_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = DEF_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT = DEF_CRC_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic [CRC_W-1:0]  crc_out,
    output logic              frame_done
);

    localparam int               CNT_W     = cnt_width(DATA_W, CRC_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CRC_W-1:0]    crc_cap_q, crc_cap_d;
    logic [CRC_W-1:0]    crc_out_q, crc_out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CRC_W-1:0]    crc_step;
    logic                done_d;
    logic                ready_d, valid_d, bit_d, sof_d, eof_d;
    logic                ready_q, valid_q, bit_q, sof_q, eof_q, done_q;

    crc_serial_tx_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_i (crc_q),
        .bit_i (shift_q[DATA_W-1]),
        .crc_o (crc_step)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        crc_cap_d = crc_cap_q;
        crc_out_d = crc_out_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    shift_d = data_in;
                    crc_d   = CRC_INIT;
                    cnt_d   = DATA_LAST;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // tx_valid is always high here, so tx_ready alone means a transfer
                if (tx_ready) begin
                    crc_d   = crc_step;
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        // Final remainder is known now; keep a copy because the
                        // LFSR itself is consumed while the CRC bits shift out.
                        crc_cap_d = crc_step;
                        cnt_d     = CRC_LAST;
                        state_d   = ST_CRC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (tx_ready) begin
                    crc_d = {crc_q[CRC_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        crc_out_d = crc_cap_q;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state so they hold during stalls.
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d != ST_IDLE);
        sof_d   = (state_d == ST_DATA) && (cnt_d == DATA_LAST);
        eof_d   = (state_d == ST_CRC)  && (cnt_d == '0);
        if (state_d == ST_DATA)     bit_d = shift_d[DATA_W-1];
        else if (state_d == ST_CRC) bit_d = crc_d[CRC_W-1];
        else                        bit_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            crc_q     <= '0;
            crc_cap_q <= '0;
            crc_out_q <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            bit_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            crc_cap_q <= crc_cap_d;
            crc_out_q <= crc_out_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            bit_q     <= bit_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
        end
    end

    assign data_ready = ready_q;
    assign tx_valid   = valid_q;
    assign tx_bit     = bit_q;
    assign tx_sof     = sof_q;
    assign tx_eof     = eof_q;
    assign crc_out    = crc_out_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_crc_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_crc_serial_tx
//   Self-checking bench for crc_serial_tx (DATA_W=7, CRC_W=3, x^3+x+1).
//   Expected serial bits and CRCs are queued when a word is offered and are
//   compared by a monitor as the DUT presents and transfers bits.
// ---------------------------------------------------------------------------
module tb_crc_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [6:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sof;
    logic       tx_eof;
    logic [2:0] crc_out;
    logic       frame_done;

    crc_serial_tx #(
        .DATA_W   (7),
        .CRC_W    (3),
        .POLY     (3'b011),
        .CRC_INIT (3'b000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .crc_out    (crc_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic sof;
        logic eof;
    } exp_bit_t;

    typedef struct {
        logic [6:0] data;
        logic [2:0] crc;
    } vec_t;

    exp_bit_t   sb[$];
    logic [2:0] crcq[$];
    int         n_checks;
    int         n_fail;
    logic       mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Reference CRC by polynomial long division of data*x^3 by 1011.
    function automatic logic [2:0] model_crc(input logic [6:0] d);
        logic [9:0] r;
        r = {d, 3'b000};
        for (int i = 9; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    task automatic push_frame(input logic [6:0] d, input logic [2:0] c);
        exp_bit_t e;
        for (int i = 0; i < 10; i++) begin
            if (i < 7) e.b = d[6-i];
            else       e.b = c[9-i];
            e.sof = (i == 0);
            e.eof = (i == 9);
            sb.push_back(e);
        end
        crcq.push_back(c);
    endtask

    // Offer one word; returns one step after the capturing edge.
    task automatic send_word(input logic [6:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        data_in    = d;
        data_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (data_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        if (!ok) fail_now("send_timeout", "data_ready never 1, expected 1");
    endtask

    // Counts cycles from the first frame cycle to frame_done inclusive.
    task automatic run_frame(input logic [6:0] d, input logic [2:0] c,
                             input bit toggle, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        push_frame(d, c);
        send_word(d);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            cycles++;
            if (frame_done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                if (toggle) tx_ready = ~tx_ready;
            end
        end
        if (!got) fail_now("frame_timeout", "frame_done=0, expected 1");
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_bit", "tx_valid=1, expected 0");
                end else begin
                    check("tx_bit", 32'(tx_bit), 32'(sb[0].b));
                    check("tx_sof", 32'(tx_sof), 32'(sb[0].sof));
                    check("tx_eof", 32'(tx_eof), 32'(sb[0].eof));
                    if (tx_ready) void'(sb.pop_front());
                end
            end
            if (frame_done) begin
                if (crcq.size() == 0) begin
                    fail_now("unexpected_done", "frame_done=1, expected 0");
                end else begin
                    check("crc_out_at_done", 32'(crc_out), 32'(crcq[0]));
                    void'(crcq.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

    vec_t       vec[6];
    int         cyc;
    logic [6:0] w[3];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        tx_ready   = 1'b0;

        vec[0] = '{7'b0000001, 3'b011};
        vec[1] = '{7'b1000000, 3'b100};
        vec[2] = '{7'b1011000, 3'b000};
        vec[3] = '{7'b1111111, model_crc(7'b1111111)};
        vec[4] = '{7'b0101010, model_crc(7'b0101010)};
        vec[5] = '{7'b1100101, model_crc(7'b1100101)};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_crc_out", 32'(crc_out), 0);
        check("rst_tx_bit", 32'(tx_bit), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_data_ready", 32'(data_ready), 1);
        check("rel_tx_valid", 32'(tx_valid), 0);
        check("rel_crc_out", 32'(crc_out), 0);
        check("rel_frame_done", 32'(frame_done), 0);
        mon_en = 1'b1;

        // Table of single frames with continuous tx_ready
        for (int v = 0; v < 6; v++) begin
            tx_ready = 1'b1;
            run_frame(vec[v].data, vec[v].crc, 1'b0, cyc);
            check("frame_cycles", 32'(cyc), 11);
            @(negedge clk);
            check("crc_out_held", 32'(crc_out), 32'(vec[v].crc));
            check("done_one_cycle", 32'(frame_done), 0);
            check("idle_ready", 32'(data_ready), 1);
        end

        // Backpressure: tx_ready alternates every cycle
        tx_ready = 1'b1;
        run_frame(7'b1000000, 3'b100, 1'b1, cyc);
        check("stall_frame_cycles", 32'(cyc), 20);
        @(negedge clk);
        check("stall_crc_out", 32'(crc_out), 32'(3'b100));
        tx_ready = 1'b1;

        // Three back-to-back words with data_valid held high
        w[0] = 7'b0110011;
        w[1] = 7'b1001110;
        w[2] = 7'b0000111;
        for (int i = 0; i < 3; i++) push_frame(w[i], model_crc(w[i]));
        @(posedge clk); #1;
        data_in    = w[0];
        data_valid = 1'b1;
        @(negedge clk);
        check("b2b_start_ready", 32'(data_ready), 1);
        @(posedge clk); #1;
        data_in = w[1];
        for (int k = 0; k < 33; k++) begin
            @(negedge clk); #1;
            check("b2b_tx_valid", 32'(tx_valid), (k % 11 != 10) ? 1 : 0);
            check("b2b_data_ready", 32'(data_ready), (k % 11 == 10) ? 1 : 0);
            @(posedge clk); #1;
            if (k == 10) data_in = w[1] ^ w[1] ^ w[2];
            if (k == 21) data_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_crc_out", 32'(crc_out), 32'(model_crc(w[2])));
        check("b2b_sb_empty", 32'(sb.size()), 0);

        // Reset pulse while bit 5 of a frame is on the line
        push_frame(7'b1111111, model_crc(7'b1111111));
        send_word(7'b1111111);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_pre_valid", 32'(tx_valid), 1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        crcq.delete();
        #1;
        check("abort_tx_valid", 32'(tx_valid), 0);
        check("abort_crc_out", 32'(crc_out), 0);
        check("abort_data_ready", 32'(data_ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(frame_done), 0);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_abort_no_done", 32'(frame_done), 0);
            check("post_abort_idle", 32'(tx_valid), 0);
        end

        // First frame after the abort must be clean
        tx_ready = 1'b1;
        run_frame(7'b0000001, 3'b011, 1'b0, cyc);
        check("post_abort_cycles", 32'(cyc), 11);
        @(negedge clk);
        check("post_abort_crc", 32'(crc_out), 32'(3'b011));
        check("final_sb_empty", 32'(sb.size()), 0);
        check("final_crcq_empty", 32'(crcq.size()), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
